aes_result_writer: RTL

Downstream write-back stage for the AES accelerator. Accepts 128-bit cipher results from the AES top-level control block, buffers them in a small FIFO, and writes each result to BRAM as four 32-bit words at consecutive addresses. It signals completion once the programmed number of blocks has been written, so software can poll a single completion flag for the whole job.

---
 rtl/aes_result_writer_if.sv | 37 +++
 rtl/aes_result_writer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_result_writer_if
//  Description : Job control, AES result handshake and BRAM write bus for
//                aes_result_writer.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_result_writer_if;
    logic          wr_start;
    logic [31:0]   wr_addr_start;
    logic [31:0]   wr_num_blocks;
    logic          res_valid;
    logic [127:0]  res_data;
    logic          res_ready;
    logic          bram_we;
    logic [31:0]   bram_addr;
    logic [31:0]   bram_wdata;
    logic          bram_ack;
    logic          wr_busy;
    logic          wr_complete;
    logic          wr_overflow;
    logic [31:0]   wr_blocks_done;

    // Master is the side that programs the job and feeds results (and acks BRAM).
    modport master (
        output wr_start, wr_addr_start, wr_num_blocks, res_valid, res_data, bram_ack,
        input  res_ready, bram_we, bram_addr, bram_wdata,
               wr_busy, wr_complete, wr_overflow, wr_blocks_done
    );

    modport slave (
        input  wr_start, wr_addr_start, wr_num_blocks, res_valid, res_data, bram_ack,
        output res_ready, bram_we, bram_addr, bram_wdata,
               wr_busy, wr_complete, wr_overflow, wr_blocks_done
    );
endinterface
`default_nettype wire

// File: rtl/aes_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_result_writer
//  Description : Buffers 128-bit AES results in a FIFO and writes each one to
//                BRAM as four 32-bit words. Define AES_WR_BYTESWAP_EN to
//                byte-reverse every word for little-endian host buffers.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_result_writer #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] ADDR_STEP  = 32'd4
) (
    input  wire logic          aes_clk,
    input  wire logic          aes_rst,
    aes_result_writer_if.slave bus
);

    localparam int                c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [127:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic [127:0]        r_shift;
    logic [1:0]          r_idx;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [31:0]         r_num;
    logic [31:0]         r_done_cnt;
    logic                r_busy;
    logic                r_complete;
    logic                r_overflow;
    logic                r_ready;

    logic                w_armed;
    logic                w_full;
    logic                w_empty;
    logic                w_flush;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_room_nxt;
    logic [c_PTR_W:0]    w_count_nxt;
    logic [127:0]        w_head;
    logic [31:0]         w_done_inc;

    function automatic logic [31:0] f_fmt_word(input logic [31:0] word);
`ifdef AES_WR_BYTESWAP_EN
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
        return word;
`endif
    endfunction

    assign w_armed    = (r_state == S_WAIT) || (r_state == S_LOAD) || (r_state == S_WRITE);
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    assign w_flush    = (r_state == S_IDLE) && bus.wr_start;
    // LOAD is only entered with a non-empty FIFO, so the pop needs no guard.
    assign w_pop      = (r_state == S_LOAD);
    assign w_push     = w_armed && bus.res_valid && (!w_full || w_pop);
    assign w_drop     = w_armed && bus.res_valid && w_full && !w_pop;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_done_inc = r_done_cnt + 32'd1;
    assign w_room_nxt = (w_count_nxt != c_DEPTH_CNT);

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + (c_PTR_W + 1)'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - (c_PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge aes_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.res_data;
        end
    end

    always_ff @(posedge aes_clk or posedge aes_rst) begin
        if (aes_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge aes_clk or posedge aes_rst) begin
        if (aes_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_num      <= '0;
            r_done_cnt <= '0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.wr_start) begin
                        r_addr     <= bus.wr_addr_start;
                        r_num      <= bus.wr_num_blocks;
                        r_done_cnt <= '0;
                        r_complete <= 1'b0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (bus.wr_num_blocks == 32'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                            r_ready <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_ready <= w_room_nxt;
                    if (!w_empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_ready <= w_room_nxt;
                    r_shift <= {w_head[95:0], 32'd0};
                    r_wdata <= f_fmt_word(w_head[127:96]);
                    r_idx   <= '0;
                    r_we    <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_ready <= w_room_nxt;
                    if (bus.bram_ack) begin
                        r_addr <= r_addr + ADDR_STEP;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_we       <= 1'b0;
                            r_done_cnt <= w_done_inc;
                            if (w_done_inc == r_num) begin
                                r_state <= S_DONE;
                                r_ready <= 1'b0;
                            end else if (!w_empty) begin
                                r_state <= S_LOAD;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_wdata <= f_fmt_word(r_shift[127:96]);
                            r_shift <= {r_shift[95:0], 32'd0};
                        end
                    end
                end
                S_DONE: begin
                    r_busy     <= 1'b0;
                    r_complete <= 1'b1;
                    r_ready    <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.res_ready      = r_ready;
    assign bus.bram_we        = r_we;
    assign bus.bram_addr      = r_addr;
    assign bus.bram_wdata     = r_wdata;
    assign bus.wr_busy        = r_busy;
    assign bus.wr_complete    = r_complete;
    assign bus.wr_overflow    = r_overflow;
    assign bus.wr_blocks_done = r_done_cnt;

endmodule
`default_nettype wire
